// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter onto a single memory port, one transaction
// outstanding, round-robin on conflict, with fetch-response dropping on flush.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              flush,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;

  state_t              state_q, state_d;
  owner_t              owner_q;
  logic                drop_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          be_q;
  logic                grant_if, grant_d, done;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_d  = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          // The current owner doubles as the last-granted flag for round-robin.
          grant_d  = d_req && (!if_req || owner_q == OWN_IF);
          grant_if = !grant_d;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          done    = mem_rvalid;
          state_d = mem_rvalid ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so nothing leaks before the reset edge.
  assign if_gnt    = rst && grant_if;
  assign d_gnt     = rst && grant_d;
  assign mem_req   = rst && (state_q == ISSUE);
  assign busy      = rst && (state_q != IDLE);
  assign if_rvalid = rst && done && (owner_q == OWN_IF) && !drop_q && !flush;
  assign d_rvalid  = rst && done && (owner_q == OWN_D);
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  // NOTE: state registers use non-blocking assignments so all of them update
  // from the same pre-edge values; the synchronous reset clears every one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      drop_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant_if || grant_d) begin
        owner_q <= grant_d ? OWN_D : OWN_IF;
        we_q    <= grant_d && d_we;
        addr_q  <= grant_d ? d_addr : if_addr;
        wdata_q <= grant_d ? d_wdata : '0;
        // Fetches read a full word.
        be_q    <= grant_d ? d_be : 4'b1111;
      end
      if (state_d == IDLE)
        drop_q <= 1'b0;
      else if (flush && owner_q == OWN_IF && state_q != IDLE)
        drop_q <= 1'b1;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: `clk` is the single clock; `rst` is synchronous and active-low, so `rst`=0 at a `clk` rising edge resets the block.
REQ-002 The block SHALL have these parameters, one per line as name, default, meaning:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
REQ-003 The block SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted.
- if_rvalid  out  1  fetch data valid.
- if_rdata  out  DATA_W  fetch data.
- flush  in  1  discard any outstanding fetch response.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  1  1 = store.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_be  in  4  byte enables.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  load data or store completion.
- d_rdata  out  DATA_W  load data.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  4  memory byte enables.
- mem_ack  in  1  memory accepted mem_req.
- mem_rvalid  in  1  memory response; one per accepted request, reads and writes.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  state is not IDLE.

Function
REQ-004 The FSM SHALL have three states: IDLE, ISSUE, WAIT; at most one memory transaction is outstanding.
REQ-005 In IDLE with any request, the block SHALL assert exactly one gnt combinationally in that cycle, latch owner/we/addr/wdata/be, and enter ISSUE.
REQ-006 When if_req and d_req are both asserted in IDLE, the block SHALL grant the port not granted most recently (round-robin); the last-owner flag resets to IF, so the first conflict goes to data.
REQ-007 When only one port requests, the block SHALL grant it regardless of the last-owner flag.
REQ-008 In ISSUE, mem_req SHALL be 1 and mem_* SHALL carry the latched fields; on mem_ack the block SHALL go to WAIT, or straight to IDLE if mem_rvalid=1 in the same cycle.
REQ-009 In WAIT, on mem_rvalid the block SHALL go to IDLE; mem_req SHALL be 0 in WAIT and IDLE.
REQ-010 Response routing: in the mem_rvalid cycle, the owner's rvalid SHALL be asserted combinationally, with its rdata = mem_rdata; the other port's rvalid SHALL be 0.
REQ-011 if_rdata and d_rdata SHALL always equal mem_rdata and are meaningful only while the matching rvalid is asserted.
REQ-012 mem_rvalid while in IDLE SHALL be ignored; no rvalid output is asserted.
REQ-013 flush=1 while the owner is IF in ISSUE or WAIT SHALL set a drop flag; the memory transaction still completes, but if_rvalid SHALL be suppressed for it.
REQ-014 The drop flag SHALL clear on return to IDLE.
REQ-015 flush in the same cycle as mem_rvalid for an IF transaction SHALL suppress that if_rvalid.
REQ-016 flush in IDLE, or while the owner is data, SHALL have no effect.
REQ-017 Minimum latency SHALL be: gnt in cycle 0, mem_req in cycle 1, rvalid in cycle 1 if memory acks and responds in cycle 1.
REQ-018 No new gnt SHALL be issued before the current transaction's mem_rvalid; back-to-back grants are possible in the cycle after completion.
REQ-019 busy SHALL be 1 in ISSUE and WAIT.

Reset
REQ-020 While rst=0 at a clk edge, the state SHALL go to IDLE, the last-owner flag to IF, and the drop flag to 0; all latched fields SHALL clear to 0.
REQ-021 During and after reset, mem_req, if_gnt, d_gnt, if_rvalid, d_rvalid and busy SHALL be 0 until the next request.
REQ-022 A reset in ISSUE or WAIT SHALL abandon the transaction without any rvalid; the memory is reset together with this block.

Verification
REQ-023 Single fetch: if_req=1, if_addr=0x100; memory acks in cycle 1 and responds with 0xDEADBEEF in cycle 3 -> if_gnt in cycle 0, mem_req in cycle 1, if_rvalid=1 with rdata 0xDEADBEEF in cycle 3, busy in cycles 1-3.
REQ-024 Conflict after reset: if_req and d_req held together -> first grant to data, second to IF, third to data; no cycle has both gnts.
REQ-025 Store: d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_be=4'b0011 -> mem_* carries exactly those values until mem_ack; d_rvalid is asserted on mem_rvalid.
REQ-026 Flush: fetch granted, flush pulsed in WAIT, then mem_rvalid -> if_rvalid stays 0, IDLE is reached, and the next fetch returns data normally.
REQ-027 Same-cycle ack+rvalid, and a stalled memory (mem_ack delayed 5 cycles) -> mem_req is held stable for the full 6 cycles, exactly one rvalid is produced, and there are no extra grants.
REQ-028 Reset in WAIT: rst=0 for one cycle -> all outputs are 0 and a later mem_rvalid is ignored.
